seven_seg_ascii_scan: RTL and testbench

//  Display stage downstream of the demo datapaths (ALU and other board demos).

---
 rtl/seven_seg_ascii_scan.sv | 146 ++++++++++++++
 tb/tb_seven_seg_ascii_scan.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seven_seg_ascii_scan.sv
// Scans a 4-character ASCII word onto a 4-digit common-anode 7-segment display.
// The word is latched only at frame boundaries, with ghost blanking and an optional blink.
module seven_seg_ascii_scan #(
    parameter int DIV        = 100000,
    parameter int BLANK      = 1000,
    parameter int BLINK_HALF = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] WORD,
    input  logic [3:0]  DOTS,
    input  logic        BLINK,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        DP,
    output logic        FRAME
);
    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic [31:0]   shown;
    logic [3:0]    shown_dots;

    logic          slot_end;
    logic          frame_end;
    logic          blank;
    logic [7:0]    cur_char;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

    // Letters fold to lowercase so one table serves both cases.
    function automatic logic [6:0] glyph(input logic [7:0] ch);
        logic [7:0] c;
        c = (ch >= 8'h41 && ch <= 8'h5A) ? (ch | 8'h20) : ch;
        case (c)
            8'h20:   glyph = 7'b1111111;
            8'h2D:   glyph = 7'b0111111;
            8'h5F:   glyph = 7'b1110111;
            8'h30:   glyph = 7'b1000000;
            8'h31:   glyph = 7'b1111001;
            8'h32:   glyph = 7'b0100100;
            8'h33:   glyph = 7'b0110000;
            8'h34:   glyph = 7'b0011001;
            8'h35:   glyph = 7'b0010010;
            8'h36:   glyph = 7'b0000010;
            8'h37:   glyph = 7'b1111000;
            8'h38:   glyph = 7'b0000000;
            8'h39:   glyph = 7'b0010000;
            8'h61:   glyph = 7'b0001000;
            8'h62:   glyph = 7'b0000011;
            8'h63:   glyph = 7'b0100111;
            8'h64:   glyph = 7'b0100001;
            8'h65:   glyph = 7'b0000110;
            8'h66:   glyph = 7'b0001110;
            8'h67:   glyph = 7'b0010000;
            8'h68:   glyph = 7'b0001011;
            8'h69:   glyph = 7'b1111011;
            8'h6A:   glyph = 7'b1100001;
            8'h6C:   glyph = 7'b1000111;
            8'h6E:   glyph = 7'b0101011;
            8'h6F:   glyph = 7'b0100011;
            8'h70:   glyph = 7'b0001100;
            8'h71:   glyph = 7'b0011000;
            8'h72:   glyph = 7'b0101111;
            8'h73:   glyph = 7'b0010010;
            8'h74:   glyph = 7'b0000111;
            8'h75:   glyph = 7'b1100011;
            8'h79:   glyph = 7'b0010001;
            default: glyph = 7'b0110110;
        endcase
    endfunction

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign frame_end = slot_end && (idx == 2'd3);

    always_comb begin
        cur_char = 8'h20;
        case (idx)
            2'd0: cur_char = shown[7:0];
            2'd1: cur_char = shown[15:8];
            2'd2: cur_char = shown[23:16];
            2'd3: cur_char = shown[31:24];
            default: cur_char = 8'h20;
        endcase
    end

    // BLINK is sampled live so dropping it lights the digit on the very next cycle.
    always_comb begin
        blank    = (cnt < CW'(BLANK)) || (BLINK && phase);
        an_next  = 4'b1111;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = glyph(cur_char);
            dp_next  = ~shown_dots[idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= 2'd0;
            fcnt       <= '0;
            phase      <= 1'b0;
            shown      <= 32'h20202020;
            shown_dots <= 4'b0000;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_end) begin
                shown      <= WORD;
                shown_dots <= DOTS;
                if (fcnt == FW'(BLINK_HALF - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN    <= 4'b1111;
            SEG   <= 7'h7F;
            DP    <= 1'b1;
            FRAME <= 1'b0;
        end else begin
            AN    <= an_next;
            SEG   <= seg_next;
            DP    <= dp_next;
            FRAME <= frame_end;
        end
    end
endmodule

// File: tb/tb_seven_seg_ascii_scan.sv
// Directed bench for seven_seg_ascii_scan with DIV=8, BLANK=2, BLINK_HALF=2.
// Pins are sampled on the falling edge; each slot is checked cycle by cycle.
module tb_seven_seg_ascii_scan;
    logic        clk;
    logic        rst;
    logic [31:0] word;
    logic [3:0]  dots;
    logic        blink;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G_SP = 7'b1111111;
    localparam logic [6:0] G_R  = 7'b0101111;
    localparam logic [6:0] G_D  = 7'b0100001;
    localparam logic [6:0] G_A  = 7'b0001000;
    localparam logic [6:0] G_H  = 7'b0001011;
    localparam logic [6:0] G_S  = 7'b0010010;
    localparam logic [6:0] G_MI = 7'b0111111;
    localparam logic [6:0] G_UK = 7'b0110110;

    seven_seg_ascii_scan #(.DIV(8), .BLANK(2), .BLINK_HALF(2)) dut (
        .CLK(clk), .RST(rst), .WORD(word), .DOTS(dots), .BLINK(blink),
        .SEG(seg), .AN(an), .DP(dp), .FRAME(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares the packed pin bundle {AN, SEG, DP, FRAME}.
    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b frame=%b, expected an=%b seg=%b dp=%b frame=%b",
                     tag, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                              input logic dp_e, input logic frame_last, input logic dark);
        logic [12:0] exp;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (dark || c < 2) exp = {4'b1111, 7'h7F, 1'b1, frame_last && (c == 7)};
            else               exp = {an_e, seg_e, dp_e, frame_last && (c == 7)};
            check($sformatf("%s c%0d", tag, c), {an, seg, dp, frame}, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                               input logic dark);
        check_slot({tag, " s0"}, 4'b1110, segs[6:0],   dps[0], 1'b0, dark);
        check_slot({tag, " s1"}, 4'b1101, segs[13:7],  dps[1], 1'b0, dark);
        check_slot({tag, " s2"}, 4'b1011, segs[20:14], dps[2], 1'b0, dark);
        check_slot({tag, " s3"}, 4'b0111, segs[27:21], dps[3], 1'b1, dark);
    endtask

    initial begin
        rst   = 1'b1;
        word  = "addr";
        dots  = 4'b0000;
        blink = 1'b0;
        repeat (3) tick();
        check("reset held", {an, seg, dp, frame}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;
        repeat (5) tick();
        check("pre-pulse lit", {an, seg, dp, frame}, {4'b1110, G_SP, 1'b1, 1'b0});

        // Asynchronous reset in the middle of a lit slot.
        #2 rst = 1'b1;
        #1 check("async reset", {an, seg, dp, frame}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        check_frame("f0 spaces", {G_SP, G_SP, G_SP, G_SP}, 4'b1111, 1'b0);
        check_slot("f1 r", 4'b1110, G_R, 1'b1, 1'b0, 1'b0);
        check_slot("f1 d", 4'b1101, G_D, 1'b1, 1'b0, 1'b0);
        word = " shr";
        check_slot("f1 d2", 4'b1011, G_D, 1'b1, 1'b0, 1'b0);
        check_slot("f1 a", 4'b0111, G_A, 1'b1, 1'b1, 1'b0);

        // Phase is 1 during frames 2-3, but BLINK is low so they stay lit.
        check_slot("f2 r", 4'b1110, G_R, 1'b1, 1'b0, 1'b0);
        word = 32'h0141612D;
        dots = 4'b1000;
        check_slot("f2 h", 4'b1101, G_H, 1'b1, 1'b0, 1'b0);
        check_slot("f2 s", 4'b1011, G_S, 1'b1, 1'b0, 1'b0);
        check_slot("f2 sp", 4'b0111, G_SP, 1'b1, 1'b1, 1'b0);

        check_frame("f3 mixed", {G_UK, G_A, G_A, G_MI}, 4'b0111, 1'b0);

        blink = 1'b1;
        check_frame("f4 blink on", {G_UK, G_A, G_A, G_MI}, 4'b0111, 1'b0);
        check_frame("f5 blink on", {G_UK, G_A, G_A, G_MI}, 4'b0111, 1'b0);
        check_frame("f6 blink dark", {G_UK, G_A, G_A, G_MI}, 4'b0111, 1'b1);

        // Dark frame 7: drop BLINK after cnt=3 and expect the digit from cnt=4 onward.
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("f7 dark c%0d", c), {an, seg, dp, frame}, {4'b1111, 7'h7F, 1'b1, 1'b0});
        end
        blink = 1'b0;
        for (int c = 4; c < 8; c++) begin
            tick();
            check($sformatf("f7 unblink c%0d", c), {an, seg, dp, frame}, {4'b1110, G_MI, 1'b1, 1'b0});
        end
        check_slot("f7 s1", 4'b1101, G_A, 1'b1, 1'b0, 1'b0);
        check_slot("f7 s2", 4'b1011, G_A, 1'b1, 1'b0, 1'b0);
        check_slot("f7 s3", 4'b0111, G_UK, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
